dir_switch_conditioner: RTL and testbench

Conditions the raw mechanical direction switch before it reaches the S input of the 0–9 / 9–0 decade counter. The block synchronises the asynchronous pad signal, rejects contact bounce with a counter-based stability filter, and outputs a clean direction level. It also produces single-cycle edge pulses for downstream logic that must react to a direction change. It sits directly between the board switch pin and the counter's S port, on the same 50 MHz clock domain.

---
 rtl/dir_switch_pkg.sv | 25 ++
 rtl/sync_ff.sv | 40 ++++
 rtl/dir_switch_conditioner.sv | 144 ++++++++++++++
 tb/tb_dir_switch_conditioner.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dir_switch_pkg.sv
// ---------------------------------------------------------------------------
// dir_switch_pkg
//   Shared types and helpers for the direction-switch conditioner.
//   - state_t   : debounce FSM state, 2-bit encoding. Bit 1 equals the
//                 committed direction level in every state.
//   - db_cycles : number of clock cycles in the debounce window.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package dir_switch_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } state_t;

  // Cycles per millisecond times the window length in milliseconds.
  // Dividing first keeps the intermediate product within 32 bits.
  function automatic int db_cycles(input int clk_hz, input int debounce_ms);
    return (clk_hz / 1000) * debounce_ms;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
//   N-stage flop chain that brings an asynchronous level into the clk
//   domain. Reusable for any of the counter's pad inputs.
//   Ports:
//     clk    in  system clock (rising edge)
//     reset  in  asynchronous, active-high reset (chain clears to 0)
//     d      in  asynchronous input level
//     q      out synchronised level (last stage of the chain)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  // Shift the raw level in at bit 0; bit N-1 is the settled output.
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/dir_switch_conditioner.sv
// ---------------------------------------------------------------------------
// dir_switch_conditioner
//   Cleans up the mechanical direction switch feeding the decade counter's
//   S input: synchronises the pad, rejects bounce with a counter-based
//   stability filter and emits one-cycle edge pulses on each committed
//   direction change.
//   Parameters:
//     CLK_HZ       clock frequency in Hz
//     DEBOUNCE_MS  required stable time in ms (window must be >= 2 cycles)
//     SYNC_STAGES  synchroniser depth (>= 2)
//   Ports:
//     clk     in  system clock (rising edge)
//     reset   in  asynchronous, active-high reset
//     sw_raw  in  raw switch level, asynchronous to clk
//     S       out debounced direction: 0 = count up, 1 = count down
//     s_rise  out one-cycle pulse as S goes 0->1
//     s_fall  out one-cycle pulse as S goes 1->0
//     busy    out high while a candidate change is being timed
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dir_switch_conditioner
  import dir_switch_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic S,
  output logic s_rise,
  output logic s_fall,
  output logic busy
);

  localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int CNT_W     = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic samp;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             s_q,      s_d;
  logic             s_rise_q, s_rise_d;
  logic             s_fall_q, s_fall_d;

  sync_ff #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sw_raw),
    .q    (samp)
  );

  // Debounce FSM. A candidate level must be seen for DB_CYCLES consecutive
  // cycles in a WAIT state before it is committed; a single sample at the
  // old level drops back to the stable state and restarts the window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    s_rise_d = 1'b0;
    s_fall_d = 1'b0;

    unique case (state_q)
      STABLE_LO: begin
        if (samp) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end

      WAIT_HI: begin
        if (!samp) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          s_d      = 1'b1;
          s_rise_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STABLE_HI: begin
        if (!samp) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end

      WAIT_LO: begin
        if (samp) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = STABLE_LO;
          cnt_d    = '0;
          s_d      = 1'b0;
          s_fall_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        s_d     = 1'b0;
      end
    endcase
  end

  // State, counter and output registers. Reset clears every output
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      s_q      <= 1'b0;
      s_rise_q <= 1'b0;
      s_fall_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      s_rise_q <= s_rise_d;
      s_fall_q <= s_fall_d;
    end
  end

  assign S      = s_q;
  assign s_rise = s_rise_q;
  assign s_fall = s_fall_q;
  assign busy   = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_dir_switch_conditioner.sv
// ---------------------------------------------------------------------------
// tb_dir_switch_conditioner
//   Directed bench for dir_switch_conditioner with CLK_HZ=1000,
//   DEBOUNCE_MS=4 (4-cycle window, 7-edge latency) and a 20 ns clock.
//   Edge index k=0 is the first rising edge that samples a new sw_raw level.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dir_switch_conditioner;

  logic clk;
  logic reset;
  logic sw_raw;
  logic S;
  logic s_rise;
  logic s_fall;
  logic busy;

  int compareCount;
  int mismatchCount;
  int riseCount;

  dir_switch_conditioner #(
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw_raw(sw_raw),
    .S     (S),
    .s_rise(s_rise),
    .s_fall(s_fall),
    .busy  (busy)
  );

  // 20 ns clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic level);
    sw_raw = level;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follows a committed change of S to newS, with sw_raw already held at
  // the new level and the next edge being k=0.
  task automatic checkWindow(input string name, input logic newS);
    for (int k = 0; k < 9; k++) begin
      tick();
      checkOutput($sformatf("%s busy k=%0d", name, k), busy,
                  (k >= 2 && k <= 5) ? 8'd1 : 8'd0);
      checkOutput($sformatf("%s S k=%0d", name, k), S,
                  (k >= 6) ? {7'd0, newS} : {7'd0, ~newS});
      checkOutput($sformatf("%s rise k=%0d", name, k), s_rise,
                  (k == 6 && newS) ? 8'd1 : 8'd0);
      checkOutput($sformatf("%s fall k=%0d", name, k), s_fall,
                  (k == 6 && !newS) ? 8'd1 : 8'd0);
    end
  endtask

  // Expected busy after each edge for the 1,1,0,1,1,0 bounce pattern.
  logic [11:0] bounceBusy;
  // Inputs for bounce-then-settle: 1,1,0,0,1,1 then held 1.
  logic [5:0]  settleSeq;

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    riseCount     = 0;
    reset         = 1'b1;
    sw_raw        = 1'b0;
    // bit e = busy after edge e
    bounceBusy    = 12'b0000_0110_1100;
    // bit i = input for edge i
    settleSeq     = 6'b110011;

    // Power-on reset
    tick();
    tick();
    checkOutput("por S", S, 8'd0);
    checkOutput("por rise", s_rise, 8'd0);
    checkOutput("por fall", s_fall, 8'd0);
    checkOutput("por busy", busy, 8'd0);
    reset = 1'b0;
    tick();
    tick();
    checkOutput("idle S", S, 8'd0);

    // Clean rise then clean fall
    applyStimulus(1'b1);
    checkWindow("rise", 1'b1);
    applyStimulus(1'b0);
    checkWindow("fall", 1'b0);
    tick();
    tick();

    // Bounce rejection: 1,1,0,1,1,0 then held 0
    for (int e = 0; e < 12; e++) begin
      if (e < 6) applyStimulus((e == 2 || e == 5) ? 1'b0 : 1'b1);
      else       applyStimulus(1'b0);
      tick();
      checkOutput($sformatf("bounce S e=%0d", e), S, 8'd0);
      checkOutput($sformatf("bounce rise e=%0d", e), s_rise, 8'd0);
      checkOutput($sformatf("bounce busy e=%0d", e), busy,
                  {7'd0, bounceBusy[e]});
    end
    checkOutput("bounce end state", dut.state_q, 8'd0);

    // Bounce then settle high: commit at edge 10 (7 edges from edge 4)
    for (int e = 0; e < 14; e++) begin
      applyStimulus((e < 6) ? settleSeq[e] : 1'b1);
      tick();
      if (s_rise) riseCount++;
      checkOutput($sformatf("settle S e=%0d", e), S,
                  (e >= 10) ? 8'd1 : 8'd0);
      checkOutput($sformatf("settle rise e=%0d", e), s_rise,
                  (e == 10) ? 8'd1 : 8'd0);
      checkOutput($sformatf("settle fall e=%0d", e), s_fall, 8'd0);
    end
    checkOutput("settle rise count", riseCount[7:0], 8'd1);

    // Asynchronous reset mid-cycle with S=1 and the switch still high
    applyStimulus(1'b1);
    tick();
    checkOutput("pre-reset S", S, 8'd1);
    #5;
    reset = 1'b1;
    #1;
    checkOutput("async S", S, 8'd0);
    checkOutput("async rise", s_rise, 8'd0);
    checkOutput("async fall", s_fall, 8'd0);
    checkOutput("async busy", busy, 8'd0);
    tick();
    checkOutput("in-reset S", S, 8'd0);
    reset = 1'b0;
    // Next edge is the first to sample the held-high switch
    checkWindow("post-reset", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compareCount, mismatchCount);
    $finish;
  end

endmodule
